// File: rtl/config_port_arbiter_pkg.sv
// Shared definitions for the configuration-port arbiter: word width, FSM states,
// owner indices and the Grant codes reported for each owner.
package config_port_arbiter_pkg;

    localparam int CFG_W = 32;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SWITCH = 2'd1;
    localparam state_t ST_OWNED  = 2'd2;

    // Owner index doubles as priority rank: lower index wins.
    typedef logic [1:0] owner_t;
    localparam owner_t OWN_JTAG    = 2'd0;
    localparam owner_t OWN_UART    = 2'd1;
    localparam owner_t OWN_BITBANG = 2'd2;
    localparam owner_t OWN_SELF    = 2'd3;

    localparam logic [1:0] GRANT_NONE    = 2'd0;
    localparam logic [1:0] GRANT_JTAG    = 2'd1;
    localparam logic [1:0] GRANT_UART    = 2'd2;
    localparam logic [1:0] GRANT_BITBANG = 2'd3;

    function automatic logic [1:0] grant_code(owner_t o);
        case (o)
            OWN_JTAG:    return GRANT_JTAG;
            OWN_UART:    return GRANT_UART;
            OWN_BITBANG: return GRANT_BITBANG;
            default:     return GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/config_port_arbiter_if.sv
// Bundle of the per-port request/data/strobe lines and the arbitrated config-path outputs.
interface config_port_arbiter_if;
    import config_port_arbiter_pkg::*;

    logic             JTAGActive;
    logic             UART_ComActive;
    logic             BitBangActive;
    logic [CFG_W-1:0] JTAGWriteData;
    logic [CFG_W-1:0] UART_WriteData;
    logic [CFG_W-1:0] BitBangWriteData;
    logic [CFG_W-1:0] SelfWriteData;
    logic             JTAGWriteStrobe;
    logic             UART_WriteStrobe;
    logic             BitBangWriteStrobe;
    logic             SelfWriteStrobe;

    logic [CFG_W-1:0] ConfigWriteData;
    logic             ConfigWriteStrobe;
    logic             FSM_Reset;
    logic [1:0]       Grant;
    logic             SelfGrant;
    logic [7:0]       DropCount;

    modport slave (
        input  JTAGActive, UART_ComActive, BitBangActive,
        input  JTAGWriteData, UART_WriteData, BitBangWriteData, SelfWriteData,
        input  JTAGWriteStrobe, UART_WriteStrobe, BitBangWriteStrobe, SelfWriteStrobe,
        output ConfigWriteData, ConfigWriteStrobe, FSM_Reset, Grant, SelfGrant, DropCount
    );

    modport master (
        output JTAGActive, UART_ComActive, BitBangActive,
        output JTAGWriteData, UART_WriteData, BitBangWriteData, SelfWriteData,
        output JTAGWriteStrobe, UART_WriteStrobe, BitBangWriteStrobe, SelfWriteStrobe,
        input  ConfigWriteData, ConfigWriteStrobe, FSM_Reset, Grant, SelfGrant, DropCount
    );

endinterface

// File: rtl/cfg_fixed_prio_enc.sv
// Four-input fixed-priority encoder: bit 0 (JTAG) highest, bit 3 (CPU) lowest.
module cfg_fixed_prio_enc
    import config_port_arbiter_pkg::*;
(
    input  logic [3:0] req,
    output owner_t     id,
    output logic       valid
);

    // NOTE: every output gets a default before the if-chain, so no path can infer a latch.
    always_comb begin
        id    = OWN_JTAG;
        valid = 1'b1;
        if (req[0])      id = OWN_JTAG;
        else if (req[1]) id = OWN_UART;
        else if (req[2]) id = OWN_BITBANG;
        else if (req[3]) id = OWN_SELF;
        else             valid = 1'b0;
    end

endmodule

// File: rtl/config_port_arbiter.sv
// Arbitrates JTAG, UART, BitBang and CPU sources onto the single config-FSM write port,
// resyncing the FSM with an FSM_Reset pulse on every ownership change.
module config_port_arbiter
    import config_port_arbiter_pkg::*;
#(
    parameter int RESET_CYCLES = 2,
    parameter int SELF_TIMEOUT = 255
) (
    input logic                  CLK,
    input logic                  resetn,
    config_port_arbiter_if.slave bus
);

    state_t           state, state_nx;
    owner_t           owner, pick;
    logic             pick_valid;
    logic [3:0]       rst_cnt;
    logic             fsm_rst;
    logic             buf_valid;
    logic [CFG_W-1:0] buf_data;
    logic             self_req;
    logic [7:0]       idle_cnt;
    logic             out_stb;
    logic [CFG_W-1:0] out_data;
    logic [7:0]       drop_cnt;
    logic [2:0]       drops;
    logic [8:0]       drop_sum;

    logic [3:0]       req, stb;
    logic [CFG_W-1:0] data [4];
    logic             owner_live, owner_stb;

    assign req     = {self_req, bus.BitBangActive, bus.UART_ComActive, bus.JTAGActive};
    assign stb     = {bus.SelfWriteStrobe, bus.BitBangWriteStrobe,
                      bus.UART_WriteStrobe, bus.JTAGWriteStrobe};
    assign data[0] = bus.JTAGWriteData;
    assign data[1] = bus.UART_WriteData;
    assign data[2] = bus.BitBangWriteData;
    assign data[3] = bus.SelfWriteData;

    assign owner_live = (state != ST_IDLE) && req[owner];
    assign owner_stb  = owner_live && stb[owner];

    cfg_fixed_prio_enc u_prio (
        .req   (req),
        .id    (pick),
        .valid (pick_valid)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (pick_valid) state_nx = ST_SWITCH;
            ST_SWITCH: begin
                if (!req[owner])                          state_nx = ST_IDLE;
                else if (rst_cnt == 4'(RESET_CYCLES - 1)) state_nx = ST_OWNED;
            end
            ST_OWNED:  if (!req[owner]) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        drops = '0;
        for (int i = 0; i < 4; i++)
            if (stb[i] && !(owner_live && owner == owner_t'(i))) drops = drops + 3'd1;
        // Second strobe in SWITCH finds the slot taken; a departing owner forfeits its held word.
        if (state == ST_SWITCH && owner_stb && buf_valid) drops = drops + 3'd1;
        if (state != ST_IDLE && !owner_live && buf_valid) drops = drops + 3'd1;
        drop_sum = {1'b0, drop_cnt} + {6'd0, drops};
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            owner     <= OWN_JTAG;
            rst_cnt   <= '0;
            fsm_rst   <= 1'b1;
            buf_valid <= 1'b0;
            // NOTE: the hold word is one plain register, not RAM, so it is reset with the rest.
            buf_data  <= '0;
            self_req  <= 1'b0;
            idle_cnt  <= '0;
            out_stb   <= 1'b0;
            out_data  <= '0;
            drop_cnt  <= '0;
        end else begin
            state    <= state_nx;
            fsm_rst  <= (state_nx == ST_SWITCH);
            rst_cnt  <= (state == ST_SWITCH) ? rst_cnt + 4'd1 : 4'd0;
            drop_cnt <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
            if (state == ST_IDLE) owner <= pick;

            out_stb <= 1'b0;
            if (!owner_live) begin
                buf_valid <= 1'b0;
            end else if (state == ST_SWITCH) begin
                if (stb[owner] && !buf_valid) begin
                    buf_valid <= 1'b1;
                    buf_data  <= data[owner];
                end
            end else if (buf_valid) begin
                // Held word leaves first; a live word behind it takes the slot to keep order.
                out_stb   <= 1'b1;
                out_data  <= buf_data;
                buf_valid <= stb[owner];
                if (stb[owner]) buf_data <= data[owner];
            end else if (stb[owner]) begin
                out_stb  <= 1'b1;
                out_data <= data[owner];
            end

            if (stb[3]) begin
                self_req <= 1'b1;
                idle_cnt <= '0;
            end else if (self_req) begin
                if (idle_cnt == 8'(SELF_TIMEOUT - 1)) begin
                    self_req <= 1'b0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.ConfigWriteData   = out_data;
    assign bus.ConfigWriteStrobe = out_stb;
    assign bus.FSM_Reset         = fsm_rst;
    assign bus.Grant             = (state == ST_IDLE) ? GRANT_NONE : grant_code(owner);
    assign bus.SelfGrant         = (state != ST_IDLE) && (owner == OWN_SELF);
    assign bus.DropCount         = drop_cnt;

endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed bench for config_port_arbiter: queue-based session model compared every cycle,
// plus hand-computed checkpoints for each scenario.
module tb_config_port_arbiter;

    localparam int RC = 2;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    config_port_arbiter_if ifc ();

    config_port_arbiter #(.RESET_CYCLES(RC), .SELF_TIMEOUT(ST)) dut (
        .CLK    (clk),
        .resetn (rst_n),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 resync, 2 owned; owner is port index 0..3 (JTAG..CPU).
    int          m_phase, m_owner, m_sw_left, m_quiet, m_drops;
    bit          m_took, m_self_req, m_in_reset, e_stb;
    logic [31:0] e_data;
    logic [31:0] m_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_sw_left = 0; m_quiet = 0; m_drops = 0;
        m_took = 0; m_self_req = 0; m_in_reset = 1; e_stb = 0; e_data = '0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit [3:0]    act, stb;
        logic [31:0] d [4];
        bit          live;
        int          drops = 0;
        act  = {m_self_req, ifc.BitBangActive, ifc.UART_ComActive, ifc.JTAGActive};
        stb  = {ifc.SelfWriteStrobe, ifc.BitBangWriteStrobe, ifc.UART_WriteStrobe, ifc.JTAGWriteStrobe};
        d[0] = ifc.JTAGWriteData; d[1] = ifc.UART_WriteData;
        d[2] = ifc.BitBangWriteData; d[3] = ifc.SelfWriteData;
        m_in_reset = 0;
        e_stb = 0;
        live = (m_phase != 0) && act[m_owner];
        for (int i = 0; i < 4; i++)
            if (stb[i] && !(live && i == m_owner)) drops++;
        if (m_phase == 0) begin
            if (act != 0) begin
                for (int i = 3; i >= 0; i--) if (act[i]) m_owner = i;
                m_phase = 1; m_sw_left = RC; m_took = 0;
            end
        end else if (!live) begin
            drops += m_q.size();
            m_q.delete();
            m_phase = 0;
        end else if (m_phase == 1) begin
            if (stb[m_owner]) begin
                if (m_took) drops++;
                else begin m_q.push_back(d[m_owner]); m_took = 1; end
            end
            m_sw_left--;
            if (m_sw_left == 0) m_phase = 2;
        end else begin
            if (stb[m_owner]) m_q.push_back(d[m_owner]);
            if (m_q.size() > 0) begin e_stb = 1; e_data = m_q.pop_front(); end
        end
        m_drops = (m_drops + drops > 255) ? 255 : m_drops + drops;
        if (stb[3]) begin m_self_req = 1; m_quiet = 0; end
        else if (m_self_req) begin
            m_quiet++;
            if (m_quiet == ST) begin m_self_req = 0; m_quiet = 0; end
        end
    endtask

    function automatic logic [31:0] exp_grant();
        if (m_phase == 0 || m_owner == 3) return 32'd0;
        return 32'(m_owner + 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        check("cyc_strobe",     32'(ifc.ConfigWriteStrobe), 32'(e_stb));
        check("cyc_data",       ifc.ConfigWriteData, e_data);
        check("cyc_fsm_reset",  32'(ifc.FSM_Reset), 32'(m_in_reset || m_phase == 1));
        check("cyc_grant",      32'(ifc.Grant), exp_grant());
        check("cyc_self_grant", 32'(ifc.SelfGrant), 32'(m_phase != 0 && m_owner == 3));
        check("cyc_drop_count", 32'(ifc.DropCount), 32'(m_drops));
    end

    task automatic clear_inputs();
        ifc.JTAGActive = 0; ifc.UART_ComActive = 0; ifc.BitBangActive = 0;
        ifc.JTAGWriteStrobe = 0; ifc.UART_WriteStrobe = 0;
        ifc.BitBangWriteStrobe = 0; ifc.SelfWriteStrobe = 0;
        ifc.JTAGWriteData = '0; ifc.UART_WriteData = '0;
        ifc.BitBangWriteData = '0; ifc.SelfWriteData = '0;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        clear_inputs();
        #6;
        check("rst_fsm_reset", 32'(ifc.FSM_Reset), 32'd1);
        check("rst_strobe",    32'(ifc.ConfigWriteStrobe), 32'd0);
        check("rst_grant",     32'(ifc.Grant), 32'd0);
        check("rst_drops",     32'(ifc.DropCount), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_fsm_reset", 32'(ifc.FSM_Reset), 32'd0);

        // BitBang session with a single word
        ifc.BitBangActive = 1;
        @(negedge clk);
        check("bb_sw1_fsm", 32'(ifc.FSM_Reset), 32'd1);
        check("bb_sw1_grant", 32'(ifc.Grant), 32'd3);
        @(negedge clk);
        check("bb_sw2_fsm", 32'(ifc.FSM_Reset), 32'd1);
        @(negedge clk);
        check("bb_own_fsm", 32'(ifc.FSM_Reset), 32'd0);
        ifc.BitBangWriteStrobe = 1; ifc.BitBangWriteData = 32'hDEAD_BEEF;
        @(negedge clk);
        ifc.BitBangWriteStrobe = 0;
        check("bb_out_strobe", 32'(ifc.ConfigWriteStrobe), 32'd1);
        check("bb_out_data", ifc.ConfigWriteData, 32'hDEAD_BEEF);
        @(negedge clk);
        check("bb_hold_data", ifc.ConfigWriteData, 32'hDEAD_BEEF);
        ifc.BitBangActive = 0;
        @(negedge clk);

        // UART owns; JTAG rises but must wait, its strobes are dropped
        ifc.UART_ComActive = 1;
        repeat (3) @(negedge clk);
        ifc.JTAGActive = 1; ifc.JTAGWriteStrobe = 1; ifc.JTAGWriteData = 32'h0000_0BAD;
        @(negedge clk);
        @(negedge clk);
        ifc.JTAGWriteStrobe = 0;
        check("nopre_grant", 32'(ifc.Grant), 32'd2);
        check("nopre_drops", 32'(ifc.DropCount), 32'd2);
        ifc.UART_ComActive = 0;
        @(negedge clk);
        check("uart_drop_idle", 32'(ifc.Grant), 32'd0);
        @(negedge clk);
        check("jtag_switch_grant", 32'(ifc.Grant), 32'd1);
        ifc.JTAGActive = 0;
        @(negedge clk);

        // Buffered SWITCH word colliding with a live word in the first OWNED cycle
        ifc.UART_ComActive = 1;
        @(negedge clk);
        ifc.UART_WriteStrobe = 1; ifc.UART_WriteData = 32'h11;
        @(negedge clk);
        ifc.UART_WriteData = 32'h22;
        @(negedge clk);
        check("buf_drop_second", 32'(ifc.DropCount), 32'd3);
        ifc.UART_WriteData = 32'h33;
        @(negedge clk);
        ifc.UART_WriteStrobe = 0;
        check("buf_first_out", ifc.ConfigWriteData, 32'h11);
        @(negedge clk);
        check("buf_second_out", ifc.ConfigWriteData, 32'h33);
        check("buf_second_stb", 32'(ifc.ConfigWriteStrobe), 32'd1);
        ifc.UART_WriteStrobe = 1; ifc.UART_WriteData = 32'hA0;
        @(negedge clk);
        ifc.UART_WriteData = 32'hA1;
        @(negedge clk);
        ifc.UART_WriteStrobe = 0; ifc.UART_ComActive = 0;
        check("b2b_second", ifc.ConfigWriteData, 32'hA1);
        @(negedge clk);
        @(negedge clk);

        // CPU-only session with timeout
        ifc.SelfWriteStrobe = 1; ifc.SelfWriteData = 32'h5E1F_0001;
        @(negedge clk);
        ifc.SelfWriteStrobe = 0;
        @(negedge clk);
        ifc.SelfWriteStrobe = 1; ifc.SelfWriteData = 32'h5E1F_0002;
        @(negedge clk);
        ifc.SelfWriteStrobe = 0;
        @(negedge clk);
        check("cpu_self_grant", 32'(ifc.SelfGrant), 32'd1);
        check("cpu_grant_zero", 32'(ifc.Grant), 32'd0);
        @(negedge clk);
        check("cpu_out_data", ifc.ConfigWriteData, 32'h5E1F_0002);
        check("cpu_drops", 32'(ifc.DropCount), 32'd4);
        @(negedge clk); @(negedge clk);
        check("cpu_still_owner", 32'(ifc.SelfGrant), 32'd1);
        @(negedge clk);
        check("cpu_timeout", 32'(ifc.SelfGrant), 32'd0);

        // Owner leaves during SWITCH with a buffered word
        ifc.JTAGActive = 1;
        @(negedge clk);
        ifc.JTAGWriteStrobe = 1; ifc.JTAGWriteData = 32'h77;
        @(negedge clk);
        ifc.JTAGWriteStrobe = 0; ifc.JTAGActive = 0;
        @(negedge clk);
        check("discard_drops", 32'(ifc.DropCount), 32'd5);
        check("discard_idle", 32'(ifc.Grant), 32'd0);

        // Asynchronous reset mid-OWNED with the hold register full
        ifc.BitBangActive = 1;
        @(negedge clk);
        ifc.BitBangWriteStrobe = 1; ifc.BitBangWriteData = 32'h1;
        @(negedge clk);
        ifc.BitBangWriteStrobe = 0;
        @(negedge clk);
        ifc.BitBangWriteStrobe = 1; ifc.BitBangWriteData = 32'h2;
        @(negedge clk);
        ifc.BitBangWriteStrobe = 0;
        check("pre_rst_data", ifc.ConfigWriteData, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_strobe", 32'(ifc.ConfigWriteStrobe), 32'd0);
        check("arst_data",   ifc.ConfigWriteData, 32'd0);
        check("arst_fsm",    32'(ifc.FSM_Reset), 32'd1);
        check("arst_grant",  32'(ifc.Grant), 32'd0);
        check("arst_drops",  32'(ifc.DropCount), 32'd0);
        @(negedge clk);
        ifc.BitBangActive = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_strobe", 32'(ifc.ConfigWriteStrobe), 32'd0);
        check("post_rst_fsm",    32'(ifc.FSM_Reset), 32'd0);
        check("post_rst_grant",  32'(ifc.Grant), 32'd0);

        // Everyone strobes for 300 cycles: drop counter saturates
        for (int i = 0; i < 300; i++) begin
            ifc.JTAGWriteStrobe = 1; ifc.UART_WriteStrobe = 1;
            ifc.BitBangWriteStrobe = 1; ifc.SelfWriteStrobe = 1;
            ifc.JTAGWriteData = 32'hA000_0000 + 32'(i);
            ifc.SelfWriteData = 32'hC000_0000 + 32'(i);
            @(negedge clk);
        end
        clear_inputs();
        check("sat_drops", 32'(ifc.DropCount), 32'd255);
        repeat (7) @(negedge clk);
        check("sat_hold", 32'(ifc.DropCount), 32'd255);
        check("sat_idle", 32'(ifc.SelfGrant), 32'd0);

        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/config_port_arbiter.md
CONFIG_PORT_ARBITER -- requirements
Module: config_port_arbiter

Interface
REQ-001 Parameter RESET_CYCLES, default 2: FSM_Reset pulse length in CLK cycles on every grant change (range 1..15).
REQ-002 Parameter SELF_TIMEOUT, default 255: idle CLK cycles without SelfWriteStrobe that end a CPU session (range 1..255).
REQ-003 Port CLK  input  1: sole clock; all state updates on rising edge.
REQ-004 Port resetn  input  1: reset, asynchronous, active-low.
REQ-005 Ports JTAGActive, UART_ComActive, BitBangActive  input  1 each: session-request levels of the three external ports.
REQ-006 Ports JTAGWriteData, UART_WriteData, BitBangWriteData, SelfWriteData  input  32 each: per-port configuration words.
REQ-007 Ports JTAGWriteStrobe, UART_WriteStrobe, BitBangWriteStrobe, SelfWriteStrobe  input  1 each: per-port single-cycle word-valid strobes.
REQ-008 Port ConfigWriteData  output  32: registered word toward the config FSM.
REQ-009 Port ConfigWriteStrobe  output  1: registered single-cycle strobe qualifying ConfigWriteData.
REQ-010 Port FSM_Reset  output  1: config FSM resync pulse, RESET_CYCLES long.
REQ-011 Port Grant  output  2: owner code: 0=none, 1=JTAG, 2=UART, 3=BitBang; CPU owner reports 0 and asserts SelfGrant.
REQ-012 Port SelfGrant  output  1: CPU port owns the config path.
REQ-013 Port DropCount  output  8: saturating count of discarded strobes.

Function
REQ-014 States IDLE, SWITCH, OWNED; SWITCH and OWNED each carry a registered owner id.
REQ-015 CPU request is an internal level: set by SelfWriteStrobe, cleared after SELF_TIMEOUT consecutive cycles with no SelfWriteStrobe while CPU is owner or pending.
REQ-016 IDLE -> SWITCH when any request is set; owner chosen by fixed priority JTAG > UART > BitBang > CPU, sampled in that cycle.
REQ-017 SWITCH drives FSM_Reset=1 for exactly RESET_CYCLES cycles, then -> OWNED.
REQ-018 No preemption: OWNED holds the owner until its request level drops, even when a higher-priority request appears.
REQ-019 Owner request drop in SWITCH or OWNED -> IDLE next cycle; a pending buffered word is discarded and counted.
REQ-020 In OWNED, owner strobe -> ConfigWriteData/ConfigWriteStrobe registered, exactly 1 cycle latency, back-to-back strobes supported.
REQ-021 In SWITCH, the first owner strobe is held in a 1-deep buffer; the buffer issues on the first OWNED cycle; further SWITCH strobes are dropped.
REQ-022 On a buffered issue colliding with a live owner strobe in that same first OWNED cycle, the buffered word goes first and the live word is held one more cycle, preserving order.
REQ-023 Any strobe from a non-owner, or any strobe in IDLE, is dropped; DropCount increments by the number of drops per cycle (max 4), saturates at 255, never wraps.
REQ-024 ConfigWriteStrobe is never asserted while FSM_Reset=1 or in IDLE.
REQ-025 ConfigWriteData holds its last value when the strobe is low.

Reset
REQ-026 resetn low forces IDLE, Grant=0, SelfGrant=0, FSM_Reset=1, ConfigWriteStrobe=0, ConfigWriteData=0, DropCount=0, buffer empty, CPU request clear, timeout counter 0.
REQ-027 FSM_Reset deasserts on the first CLK edge after resetn rises; reset mid-session abandons the session without a completion strobe.

Structure
REQ-028 Shared config package holds the state enum, owner code constants (NONE/JTAG/UART/BITBANG), and the 32-bit config word width.
REQ-029 One sub-module, cfg_fixed_prio_enc, is natural: a 4-input fixed-priority encoder producing the owner id and a valid flag.

Verification
REQ-030 BitBangActive=1 from IDLE -> FSM_Reset high for 2 cycles, Grant=3; a strobe with 0xDEADBEEF in OWNED -> ConfigWriteStrobe one cycle later with data 0xDEADBEEF.
REQ-031 UART owner, then JTAGActive rises -> Grant stays 2 and JTAG strobes are dropped with DropCount += 1 each; UART drop -> IDLE, then SWITCH to Grant=1.
REQ-032 UART strobe with 0x11 in SWITCH cycle 1 and 0x22 in SWITCH cycle 2 -> 0x11 issued on the first OWNED edge, DropCount=1; 0x33 strobed in the first OWNED cycle appears one cycle after 0x11.
REQ-033 CPU strobes only, SELF_TIMEOUT=4 -> SelfGrant=1 after SWITCH; after 4 strobe-free cycles -> IDLE, SelfGrant=0.
REQ-034 All four ports strobe every cycle for 300 cycles with no owner -> DropCount saturates at 255 and holds.
REQ-035 resetn pulsed low mid-OWNED with the buffer full -> all outputs at reset values asynchronously, no strobe emitted, IDLE after release.
